// File: rtl/snoop_bus_ctrl.sv
// rtl/snoop_bus_ctrl.sv - shared snoop bus arbiter, broadcaster and 8-word memory responder
module snoop_bus_ctrl #(
  parameter int NCPU      = 3,
  parameter int SNOOP_CYC = 3
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [NCPU-1:0]      req,
  input  logic [NCPU*10-1:0]   req_bus,
  input  logic [NCPU-1:0]      shared_in,
  output logic [9:0]           snoop_bus,
  output logic                 snoop_valid,
  output logic [NCPU-1:0]      grant,
  output logic                 resp_valid,
  output logic [1:0]           resp_id,
  output logic [2:0]           resp_data,
  output logic                 resp_shared,
  output logic                 busy
);

  localparam int CW = $clog2(SNOOP_CYC + 1);

  typedef enum logic [1:0] {IDLE, SNOOP, MEM, RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [9:0]      word_q, word_nxt;
  logic [1:0]      id_q, id_nxt;
  logic [1:0]      last, last_nxt;
  logic [2:0]      mem [8];
  logic            mem_we;

  logic            win_found;
  logic [1:0]      win_idx;
  logic [1:0]      cand;
  logic [NCPU-1:0] id_onehot;
  logic [NCPU-1:0] win_onehot;

  logic [9:0]      snoop_bus_nxt;
  logic            snoop_valid_nxt;
  logic [NCPU-1:0] grant_nxt;
  logic            resp_valid_nxt;
  logic [1:0]      resp_id_nxt;
  logic [2:0]      resp_data_nxt;
  logic            resp_shared_nxt;

  assign id_onehot  = {{(NCPU-1){1'b0}}, 1'b1} << id_q;
  assign win_onehot = {{(NCPU-1){1'b0}}, 1'b1} << win_idx;

  // Round-robin pick: scan from the CPU after the last winner, skipping op-00 requests
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < NCPU; k++) begin
      cand = 2'((int'(last) + 1 + k) % NCPU);
      if (!win_found && req[cand] && (req_bus[int'(cand)*10 + 8 +: 2] != 2'b00)) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic; every output is registered from these values
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    word_nxt        = word_q;
    id_nxt          = id_q;
    last_nxt        = last;
    mem_we          = 1'b0;
    snoop_bus_nxt   = 10'd0;
    snoop_valid_nxt = 1'b0;
    grant_nxt       = '0;
    resp_valid_nxt  = 1'b0;
    resp_id_nxt     = resp_id;
    resp_data_nxt   = resp_data;
    resp_shared_nxt = resp_shared;
    case (state)
      IDLE: begin
        if (win_found) begin
          // The bus owns the source field: stamp it with the granted index
          word_nxt  = {req_bus[int'(win_idx)*10 + 2 +: 8], win_idx};
          id_nxt    = win_idx;
          last_nxt  = win_idx;
          grant_nxt = win_onehot;
          if (req_bus[int'(win_idx)*10 + 8 +: 2] == 2'b11) begin
            state_nxt = MEM;
          end else begin
            state_nxt       = SNOOP;
            cnt_nxt         = CW'(1);
            snoop_valid_nxt = 1'b1;
            snoop_bus_nxt   = {req_bus[int'(win_idx)*10 + 2 +: 8], win_idx};
          end
        end
      end
      SNOOP: begin
        snoop_valid_nxt = 1'b1;
        snoop_bus_nxt   = word_q;
        if (cnt == CW'(SNOOP_CYC)) begin
          // Requester's own shared_out never counts toward the shared flag
          resp_shared_nxt = |(shared_in & ~id_onehot);
          state_nxt       = MEM;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      MEM: begin
        if (word_q[9:8] == 2'b11) begin
          mem_we          = 1'b1;
          resp_data_nxt   = 3'd0;
          resp_shared_nxt = 1'b0;
        end else begin
          resp_data_nxt = mem[word_q[7:5]];
        end
        resp_valid_nxt = 1'b1;
        resp_id_nxt    = id_q;
        state_nxt      = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, snoop counter, latched request word and arbitration pointer
  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      cnt    <= '0;
      word_q <= 10'd0;
      id_q   <= 2'd0;
      last   <= 2'(NCPU - 1);
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      word_q <= word_nxt;
      id_q   <= id_nxt;
      last   <= last_nxt;
    end
  end

  // Registered outputs
  always_ff @(posedge clock) begin
    if (clear) begin
      snoop_bus   <= 10'd0;
      snoop_valid <= 1'b0;
      grant       <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= 2'd0;
      resp_data   <= 3'd0;
      resp_shared <= 1'b0;
      busy        <= 1'b0;
    end else begin
      snoop_bus   <= snoop_bus_nxt;
      snoop_valid <= snoop_valid_nxt;
      grant       <= grant_nxt;
      resp_valid  <= resp_valid_nxt;
      resp_id     <= resp_id_nxt;
      resp_data   <= resp_data_nxt;
      resp_shared <= resp_shared_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

  // Backing memory: reinitialised to mem[a] = a on every clear, written only by write-backs
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 8; i++) begin
        mem[i] <= 3'(i);
      end
    end else if (mem_we) begin
      mem[word_q[7:5]] <= word_q[4:2];
    end
  end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb/tb_snoop_bus_ctrl.sv - directed table-driven bench for snoop_bus_ctrl
module tb_snoop_bus_ctrl;

  logic        clock = 1'b0;
  logic        clear;
  logic [2:0]  req;
  logic [29:0] req_bus;
  logic [2:0]  shared_in;
  logic [9:0]  snoop_bus;
  logic        snoop_valid;
  logic [2:0]  grant;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [2:0]  resp_data;
  logic        resp_shared;
  logic        busy;

  int checks = 0;
  int errors = 0;

  snoop_bus_ctrl #(.NCPU(3), .SNOOP_CYC(3)) dut (
    .clock       (clock),
    .clear       (clear),
    .req         (req),
    .req_bus     (req_bus),
    .shared_in   (shared_in),
    .snoop_bus   (snoop_bus),
    .snoop_valid (snoop_valid),
    .grant       (grant),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_data   (resp_data),
    .resp_shared (resp_shared),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cpu;
    logic [9:0] word;
    logic [2:0] shared;
    logic       wb;
    logic [2:0] exp_grant;
    logic [9:0] exp_snoop;
    logic [2:0] exp_data;
    logic       exp_shared;
  } txn_t;

  txn_t vec [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_snoop_bus"}, snoop_bus, 0);
    check({tag, "_snoop_valid"}, snoop_valid, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_id"}, resp_id, 0);
    check({tag, "_resp_data"}, resp_data, 0);
    check({tag, "_resp_shared"}, resp_shared, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Single-requester transaction, checked cycle by cycle from E0 onward
  task automatic run_txn(input int v);
    txn_t t;
    bit got;
    t = vec[v];
    req_bus = '0;
    req_bus[t.cpu*10 +: 10] = t.word;
    req = 3'b001 << t.cpu;
    shared_in = 3'b111;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (grant != 3'b000) got = 1;
    end
    req = 3'b000;
    if (!got) begin
      timeout($sformatf("v%0d_grant", v));
      return;
    end
    check($sformatf("v%0d_grant", v), grant, t.exp_grant);
    check($sformatf("v%0d_busy", v), busy, 1);
    if (!t.wb) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("v%0d_snoop_valid_c%0d", v, c), snoop_valid, 1);
        check($sformatf("v%0d_snoop_bus_c%0d", v, c), snoop_bus, t.exp_snoop);
        check($sformatf("v%0d_resp_early_c%0d", v, c), resp_valid, 0);
        if (c == 1) check($sformatf("v%0d_grant_pulse", v), grant, 0);
        shared_in = (c == 2) ? t.shared : 3'b111;
        @(negedge clock);
      end
    end else begin
      check($sformatf("v%0d_wb_no_snoop", v), snoop_valid, 0);
      @(negedge clock);
      check($sformatf("v%0d_grant_pulse", v), grant, 0);
    end
    check($sformatf("v%0d_resp_valid", v), resp_valid, 1);
    check($sformatf("v%0d_resp_id", v), resp_id, t.cpu);
    check($sformatf("v%0d_resp_data", v), resp_data, t.exp_data);
    check($sformatf("v%0d_resp_shared", v), resp_shared, t.exp_shared);
    check($sformatf("v%0d_snoop_off", v), snoop_valid, 0);
    @(negedge clock);
    check($sformatf("v%0d_resp_pulse", v), resp_valid, 0);
    check($sformatf("v%0d_idle", v), busy, 0);
    shared_in = 3'b000;
  endtask

  initial begin
    logic [2:0] gval [$];
    int         gcyc [$];
    logic [1:0] rid  [$];
    logic [2:0] rdat [$];
    logic [2:0] exp_g [4];
    logic [2:0] exp_d [4];
    bit         got;
    int         late;

    //        cpu word           shr     wb    grant   snoop          data  shared
    vec[0] = '{0, 10'b01_101_000_00, 3'b000, 1'b0, 3'b001, 10'b01_101_000_00, 3'd5, 1'b0};
    vec[1] = '{1, 10'b01_011_000_11, 3'b110, 1'b0, 3'b010, 10'b01_011_000_01, 3'd3, 1'b1};
    vec[2] = '{2, 10'b11_100_111_00, 3'b000, 1'b1, 3'b100, 10'b00_000_000_00, 3'd0, 1'b0};
    vec[3] = '{0, 10'b01_100_000_00, 3'b100, 1'b0, 3'b001, 10'b01_100_000_00, 3'd7, 1'b1};
    vec[4] = '{1, 10'b10_100_101_00, 3'b001, 1'b0, 3'b010, 10'b10_100_101_01, 3'd7, 1'b1};
    vec[5] = '{2, 10'b01_100_000_00, 3'b100, 1'b0, 3'b100, 10'b01_100_000_10, 3'd7, 1'b0};
    vec[6] = '{0, 10'b11_000_110_00, 3'b000, 1'b1, 3'b001, 10'b00_000_000_00, 3'd0, 1'b0};
    vec[7] = '{1, 10'b01_000_000_00, 3'b000, 1'b0, 3'b010, 10'b01_000_000_01, 3'd6, 1'b0};

    clear = 1'b1;
    req = 3'b000;
    req_bus = '0;
    shared_in = 3'b000;
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    clear = 1'b0;
    @(negedge clock);

    for (int v = 0; v < 8; v++) run_txn(v);

    // Round-robin with all three requesting continuously
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    req_bus = {10'b01_111_000_00, 10'b01_010_000_00, 10'b01_001_000_00};
    req = 3'b111;
    for (int cyc = 0; cyc < 60 && gval.size() < 4; cyc++) begin
      @(negedge clock);
      if (grant != 3'b000) begin
        gval.push_back(grant);
        gcyc.push_back(cyc);
      end
      if (resp_valid) begin
        rid.push_back(resp_id);
        rdat.push_back(resp_data);
      end
    end
    req = 3'b000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (resp_valid) begin
        rid.push_back(resp_id);
        rdat.push_back(resp_data);
      end
    end
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_d = '{3'd1, 3'd2, 3'd7, 3'd1};
    if (gval.size() < 4) begin
      timeout("rr_grants");
    end else begin
      for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), gval[i], exp_g[i]);
      for (int i = 0; i < 3; i++) check($sformatf("rr_gap%0d", i), gcyc[i+1] - gcyc[i], 6);
    end
    check("rr_resp_count", rid.size(), 4);
    for (int i = 0; i < 4 && i < rid.size(); i++) begin
      check($sformatf("rr_resp_id%0d", i), rid[i], i % 3);
      check($sformatf("rr_resp_data%0d", i), rdat[i], exp_d[i]);
    end

    // Write-back addr 4, then clear in the middle of a snoop
    run_txn(2);
    req_bus = '0;
    req_bus[9:0] = 10'b01_100_000_00;
    req = 3'b001;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (grant != 3'b000) got = 1;
    end
    req = 3'b000;
    if (!got) timeout("clr_grant");
    @(negedge clock);
    check("clr_in_snoop", snoop_valid, 1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check_reset_outputs("clr");
    late = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (resp_valid || busy) late++;
    end
    check("clr_dropped", late, 0);

    // After clear CPU0 must win over CPU1 and memory must be back to mem[a] = a
    req_bus = {10'd0, 10'b01_000_000_00, 10'b01_100_000_00};
    req = 3'b011;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (grant != 3'b000) got = 1;
    end
    req = 3'b000;
    if (!got) timeout("post_clr_grant");
    else check("post_clr_grant", grant, 3'b001);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (resp_valid) got = 1;
    end
    if (!got) timeout("post_clr_resp");
    else begin
      check("post_clr_resp_id", resp_id, 0);
      check("post_clr_mem_reinit", resp_data, 3'd4);
    end
    for (int i = 0; i < 3; i++) @(negedge clock);

    // Op 00 request is never granted
    req_bus = '0;
    req_bus[9:0] = 10'b00_101_000_00;
    req = 3'b001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check($sformatf("op00_grant%0d", i), grant, 0);
      check($sformatf("op00_busy%0d", i), busy, 0);
    end
    req = 3'b000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
